sobel_window_gen: RTL and testbench
===================================

Name: sobel_window_gen

Overview:
- Upstream neighbour of the Sobel core.
- Converts a raster-order grayscale pixel stream (valid/ready) into a 3x3 sobel_matrix window per interior pixel.
- Uses two on-chip line buffers and a 3x3 shift window; the output feeds the Sobel core's matrix_pixels_i through a registered valid/ready stage.
- Only fully populated windows are emitted: output image is (IMG_WIDTH-2) x (IMG_HEIGHT-2).

Parameters:
- IMG_WIDTH, 640, pixels per line; >= 3.
- IMG_HEIGHT, 480, lines per frame; >= 3.
- PIXEL_WIDTH_IN, 8, grayscale pixel width (package constant; parameter here for override).

Ports:
- clk_i  in  1  clock; all logic rising-edge.
- nreset_i  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous flush: restart frame position, drop pending output.
- pixel_i  in  PIXEL_WIDTH_IN  input grayscale pixel, raster order.
- pixel_valid_i  in  1  pixel_i valid.
- pixel_ready_o  out  1  block accepts pixel this cycle.
- matrix_pixels_o  out  sobel_matrix  3x3 window. vector0 = oldest row (r-2), vector2 = newest row (r); pix0 = oldest column (c-2), pix2 = newest column (c).
- matrix_valid_o  out  1  matrix_pixels_o valid.
- matrix_ready_i  in  1  downstream accepts window.
- frame_done_o  out  1  one-cycle pulse when the last pixel of a frame is accepted.

Behaviour:
- Reset (nreset_i low, async):
  - matrix_valid_o=0, matrix_pixels_o=0, frame_done_o=0.
  - col/row counters=0, window registers=0.
  - Line buffer RAM is not reset.
- pixel_ready_o = !clear_i && (!matrix_valid_o || matrix_ready_i). This is combinational.
- Accept = pixel_valid_i && pixel_ready_o. On accept at position (row r, col c):
  - new column = {lb1[c], lb0[c], pixel_i}, i.e. rows r-2, r-1, r.
  - lb1[c] <= lb0[c]; lb0[c] <= pixel_i.
  - Window shifts left per row: pix0<=pix1, pix1<=pix2, pix2<=new column entry.
  - col increments. At col==IMG_WIDTH-1, col<=0 and row increments.
  - At row==IMG_HEIGHT-1 && col==IMG_WIDTH-1, row<=0 and frame_done_o pulses the next cycle.
- Output:
  - Condition: an accept with r>=2 && c>=2 sets matrix_valid_o next cycle, with the shifted window on matrix_pixels_o. Latency is 1 cycle from accept.
  - The window is centred on (r-1, c-1).
  - Accepts with r<2 or c<2 update state only. Stale columns across a line wrap are never emitted.
- Output hold:
  - While matrix_valid_o && !matrix_ready_i, matrix_pixels_o and matrix_valid_o are stable and no pixel is accepted.
  - matrix_ready_i with no new qualifying accept → matrix_valid_o<=0.
  - Simultaneous output handshake and qualifying accept → matrix_valid_o stays 1 with new data, giving full throughput of 1 window/cycle.
- clear_i: next cycle, counters=0 and matrix_valid_o=0. The pending window is discarded and no accept happens in the clear cycle. Line buffers are untouched; the first two rows after a clear are suppressed anyway.
- Frame-to-frame: there are no gaps or sideband signals. Frame N+1 row 0 overwrites buffers, and the row<2 suppression prevents mixing of frames.
- Per frame, exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows are emitted.
- Widths: counters are $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT) bits. No arithmetic on pixel data.

Decomposition:
- Shared package (sobel_control.svh):
  - sobel_vector typedef {pix0, pix1, pix2}.
  - sobel_matrix typedef {vector0, vector1, vector2}.
  - PIXEL_WIDTH_IN, IMG_WIDTH, IMG_HEIGHT defaults.
- One sub-module: sobel_line_buffer. It is a single-port-per-cycle, read-before-write RAM of IMG_WIDTH x (2*PIXEL_WIDTH_IN) holding {lb1, lb0}, with a combinational read and a write on accept.
- The top level holds counters, window registers and the handshake.

Test Plan (IMG_WIDTH=5, IMG_HEIGHT=4, pixel = row*16+col):
- Ramp one frame, valid always, ready always:
  - First matrix_valid_o occurs 1 cycle after accepting pixel 0x22, with vector0={00,01,02}, vector1={10,11,12}, vector2={20,21,22}.
  - Exactly 6 windows are emitted; the last has vector2={32,33,34}.
  - frame_done_o pulses once.
- Backpressure: matrix_ready_i low for 3 cycles while the window for 0x23 is pending:
  - matrix_pixels_o is stable, pixel_ready_o=0 and no pixels are lost.
  - The output sequence is identical to the no-stall run.
- Random gaps on pixel_valid_i plus random matrix_ready_i produce the same 6 windows in order, with no duplicates.
- Two back-to-back frames, second frame pixel = 0x80+row*16+col: the second frame's first window is {80,81,82}/{90,91,92}/{A0,A1,A2}, with no frame-1 data leaking in.
- Reset: nreset_i asserted after pixel 0x21 is accepted, then a full frame is sent. All outputs are 0 during reset and exactly 6 correct windows follow.
- clear_i: pulsed while matrix_valid_o=1, then a full frame is sent. The pending window is dropped, pixel_ready_o=0 in the clear cycle, and 6 correct windows follow.

Source files
------------

// File: rtl/sobel_window_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sobel_window_gen_pkg
// Purpose  : Shared types and defaults for the Sobel window generator.
//            sobel_vector is one 3-pixel row slice {pix0, pix1, pix2}, where
//            pix0 is the oldest column. sobel_matrix stacks three vectors
//            {vector0, vector1, vector2}, where vector0 is the oldest row.
// Revision : 1.0 - initial release
// ============================================================================
package sobel_window_gen_pkg;

   localparam int DEFAULT_PIXEL_WIDTH_IN = 8;
   localparam int DEFAULT_IMG_WIDTH      = 640;
   localparam int DEFAULT_IMG_HEIGHT     = 480;

   typedef struct packed {
      logic [DEFAULT_PIXEL_WIDTH_IN-1:0] pix0;
      logic [DEFAULT_PIXEL_WIDTH_IN-1:0] pix1;
      logic [DEFAULT_PIXEL_WIDTH_IN-1:0] pix2;
   } sobel_vector;

   typedef struct packed {
      sobel_vector vector0;
      sobel_vector vector1;
      sobel_vector vector2;
   } sobel_matrix;

   // Shift one row of the window left by one column and insert the new pixel
   // as the newest column.
   function automatic sobel_vector shift_in(input sobel_vector v,
                                            input logic [DEFAULT_PIXEL_WIDTH_IN-1:0] p);
      sobel_vector r;
      r.pix0 = v.pix1;
      r.pix1 = v.pix2;
      r.pix2 = p;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_window_gen_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : sobel_line_buffer
// Purpose  : Two-line history RAM, one entry per column holding {lb1, lb0}
//            (lb1 = two rows back, lb0 = one row back). The read is
//            combinational and returns the old contents, so a read and a
//            write to the same column in one cycle are read-before-write.
//            The RAM contents are not reset.
// Ports    : clk_i     - clock
//            wr_en_i   - write strobe (pixel accepted)
//            addr_i    - column address for both read and write
//            wr_data_i - new {lb1, lb0}
//            rd_data_o - current {lb1, lb0} at addr_i
// Revision : 1.0 - initial release
// ============================================================================
module sobel_line_buffer #(
   parameter int DEPTH  = 640,
   parameter int DATA_W = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[addr_i];

endmodule
`default_nettype wire

// File: rtl/sobel_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : sobel_window_gen
// Purpose  : Turns a raster-order grayscale pixel stream into 3x3 windows,
//            one per interior pixel. The output image is
//            (IMG_WIDTH-2) x (IMG_HEIGHT-2) windows per frame.
// Ports    : clk_i, nreset_i (async, active-low), clear_i (sync flush)
//            pixel_i / pixel_valid_i / pixel_ready_o - input stream
//            matrix_pixels_o / matrix_valid_o / matrix_ready_i - window out
//            frame_done_o - pulse after the last pixel of a frame is accepted
// Note     : PIXEL_WIDTH_IN must equal the package pixel width, because the
//            sobel_matrix output type is built from the package width.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_window_gen
   import sobel_window_gen_pkg::*;
#(
   parameter int IMG_WIDTH      = DEFAULT_IMG_WIDTH,
   parameter int IMG_HEIGHT     = DEFAULT_IMG_HEIGHT,
   parameter int PIXEL_WIDTH_IN = DEFAULT_PIXEL_WIDTH_IN
) (
   input  logic                      clk_i,
   input  logic                      nreset_i,
   input  logic                      clear_i,
   input  logic [PIXEL_WIDTH_IN-1:0] pixel_i,
   input  logic                      pixel_valid_i,
   output logic                      pixel_ready_o,
   output sobel_matrix               matrix_pixels_o,
   output logic                      matrix_valid_o,
   input  logic                      matrix_ready_i,
   output logic                      frame_done_o
);

   localparam int COL_W = $clog2(IMG_WIDTH);
   localparam int ROW_W = $clog2(IMG_HEIGHT);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   sobel_matrix      win_q, win_d;
   logic             valid_q, valid_d;
   logic             frame_done_q, frame_done_d;

   logic                        accept;
   logic                        col_last;
   logic                        row_last;
   logic [2*PIXEL_WIDTH_IN-1:0] lb_rd;
   logic [2*PIXEL_WIDTH_IN-1:0] lb_wr;
   logic [PIXEL_WIDTH_IN-1:0]   lb1;
   logic [PIXEL_WIDTH_IN-1:0]   lb0;

   // A pending window that downstream has not taken blocks new pixels, so
   // the output register never needs a skid slot.
   assign pixel_ready_o = !clear_i && (!valid_q || matrix_ready_i);
   assign accept        = pixel_valid_i && pixel_ready_o;
   assign col_last      = (col_q == COL_LAST);
   assign row_last      = (row_q == ROW_LAST);

   assign lb1   = lb_rd[2*PIXEL_WIDTH_IN-1:PIXEL_WIDTH_IN];
   assign lb0   = lb_rd[PIXEL_WIDTH_IN-1:0];
   // Age the column history by one row: lb0 moves to lb1, the pixel to lb0.
   assign lb_wr = {lb0, pixel_i};

   sobel_line_buffer #(
      .DEPTH  (IMG_WIDTH),
      .DATA_W (2 * PIXEL_WIDTH_IN),
      .ADDR_W (COL_W)
   ) u_line_buffer (
      .clk_i     (clk_i),
      .wr_en_i   (accept),
      .addr_i    (col_q),
      .wr_data_i (lb_wr),
      .rd_data_o (lb_rd)
   );

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      win_d        = win_q;
      valid_d      = valid_q;
      frame_done_d = 1'b0;

      if (clear_i) begin
         col_d   = '0;
         row_d   = '0;
         valid_d = 1'b0;
      end else begin
         if (valid_q && matrix_ready_i) begin
            valid_d = 1'b0;
         end
         if (accept) begin
            win_d.vector0 = shift_in(win_q.vector0, lb1);
            win_d.vector1 = shift_in(win_q.vector1, lb0);
            win_d.vector2 = shift_in(win_q.vector2, pixel_i);
            // The first two rows and the first two columns of each line
            // leave the window partly stale (previous line or frame), so
            // only positions with two rows and two columns of history count.
            valid_d = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
            if (col_last) begin
               col_d = '0;
               if (row_last) begin
                  row_d        = '0;
                  frame_done_d = 1'b1;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end else begin
               col_d = col_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         col_q        <= '0;
         row_q        <= '0;
         win_q        <= '0;
         valid_q      <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         win_q        <= win_d;
         valid_q      <= valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   // The window registers only move on accepts, which are blocked while a
   // window is pending, so they double as the output register.
   assign matrix_pixels_o = win_q;
   assign matrix_valid_o  = valid_q;
   assign frame_done_o    = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_window_gen
// Purpose  : Self-checking bench for sobel_window_gen with a 5x4 image.
//            Expected windows come from a stored copy of each frame's image.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sobel_window_gen;
   import sobel_window_gen_pkg::*;

   localparam int W = 5;
   localparam int H = 4;

   logic        clk           = 1'b0;
   logic        nreset_i      = 1'b1;
   logic        clear_i       = 1'b0;
   logic [7:0]  pixel_i       = '0;
   logic        pixel_valid_i = 1'b0;
   logic        pixel_ready_o;
   sobel_matrix matrix_pixels_o;
   logic        matrix_valid_o;
   logic        matrix_ready_i;
   logic        frame_done_o;

   logic rdy_rand   = 1'b0;
   logic rdy_manual = 1'b1;
   logic rnd_rdy    = 1'b1;
   assign matrix_ready_i = rdy_rand ? rnd_rdy : rdy_manual;

   int checks  = 0;
   int errors  = 0;
   int win_cnt = 0;
   int fd_cnt  = 0;

   logic [71:0] exp_q [$];
   logic [7:0]  img [H][W];

   typedef struct {
      logic [7:0]  trig;
      logic [71:0] win;
   } vec_t;
   vec_t tbl [6];

   sobel_window_gen #(
      .IMG_WIDTH      (W),
      .IMG_HEIGHT     (H),
      .PIXEL_WIDTH_IN (8)
   ) dut (
      .clk_i           (clk),
      .nreset_i        (nreset_i),
      .clear_i         (clear_i),
      .pixel_i         (pixel_i),
      .pixel_valid_i   (pixel_valid_i),
      .pixel_ready_o   (pixel_ready_o),
      .matrix_pixels_o (matrix_pixels_o),
      .matrix_valid_o  (matrix_valid_o),
      .matrix_ready_i  (matrix_ready_i),
      .frame_done_o    (frame_done_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      rnd_rdy = ($urandom_range(0, 3) != 0);
   end

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference window centred on (r-1, c-1), built straight from the image.
   function automatic logic [71:0] exp_win(input int r, input int c);
      logic [71:0] w = '0;
      for (int dr = 0; dr < 3; dr++)
         for (int dc = 0; dc < 3; dc++)
            w = {w[63:0], img[r-2+dr][c-2+dc]};
      return w;
   endfunction

   // Output monitor: scoreboard pops on every handshake, plus hold checks.
   logic        prev_hold  = 1'b0;
   logic        prev_clear = 1'b0;
   logic [71:0] prev_pix   = '0;
   always @(negedge clk) begin
      if (nreset_i) begin
         if (prev_hold && !prev_clear) begin
            check("hold_valid", 72'(matrix_valid_o), 72'd1);
            check("hold_data", matrix_pixels_o, prev_pix);
         end
         if (matrix_valid_o && !matrix_ready_i)
            check("stall_pixel_ready", 72'(pixel_ready_o), 72'd0);
         if (matrix_valid_o && matrix_ready_i) begin
            win_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_window: got %h expected none", matrix_pixels_o);
            end else begin
               check("window", matrix_pixels_o, exp_q.pop_front());
            end
         end
         if (frame_done_o) fd_cnt++;
         prev_hold  = matrix_valid_o && !matrix_ready_i;
         prev_clear = clear_i;
         prev_pix   = matrix_pixels_o;
      end else begin
         prev_hold = 1'b0;
      end
   end

   task automatic send_pixel(input logic [7:0] p, input bit gaps);
      bit done = 1'b0;
      int n    = 0;
      pixel_i       = p;
      pixel_valid_i = 1'b1;
      while (!done) begin
         @(negedge clk);
         done = pixel_ready_o;
         @(posedge clk);
         #1;
         n++;
         if (!done && n >= 100) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: pixel %h not accepted after %0d cycles", p, n);
            done = 1'b1;
         end
      end
      if (gaps) begin
         pixel_valid_i = 1'b0;
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   // kind 0: pixel = base + row*16 + col; kind 1: random pixels.
   task automatic send_frame(input int kind, input int base, input bit gaps, input int stall_idx);
      logic [71:0] snap;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            img[r][c] = (kind == 0) ? 8'(base + r * 16 + c) : 8'($urandom);
      for (int r = 2; r < H; r++)
         for (int c = 2; c < W; c++)
            exp_q.push_back(exp_win(r, c));
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            send_pixel(img[r][c], gaps);
            if (r * W + c == stall_idx) begin
               snap          = matrix_pixels_o;
               rdy_manual    = 1'b0;
               pixel_i       = 8'hEE;
               pixel_valid_i = 1'b1;
               repeat (3) begin
                  @(negedge clk);
                  check("bp_valid", 72'(matrix_valid_o), 72'd1);
                  check("bp_data", matrix_pixels_o, snap);
                  check("bp_pixel_ready", 72'(pixel_ready_o), 72'd0);
               end
               @(posedge clk);
               #1;
               rdy_manual = 1'b1;
            end
         end
      end
   endtask

   task automatic drain();
      int n = 0;
      pixel_valid_i = 1'b0;
      while ((exp_q.size() != 0 || matrix_valid_o) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_pending", 72'(exp_q.size()), 72'd0);
   endtask

   task automatic check_counts(input string tag, input int wins, input int fds);
      check({tag, "_windows"}, 72'(win_cnt), 72'(wins));
      check({tag, "_frame_done"}, 72'(fd_cnt), 72'(fds));
      win_cnt = 0;
      fd_cnt  = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int hit;
      tbl[0] = '{8'h22, 72'h00_01_02_10_11_12_20_21_22};
      tbl[1] = '{8'h23, 72'h01_02_03_11_12_13_21_22_23};
      tbl[2] = '{8'h24, 72'h02_03_04_12_13_14_22_23_24};
      tbl[3] = '{8'h32, 72'h10_11_12_20_21_22_30_31_32};
      tbl[4] = '{8'h33, 72'h11_12_13_21_22_23_31_32_33};
      tbl[5] = '{8'h34, 72'h12_13_14_22_23_24_32_33_34};

      // Reset state
      #2 nreset_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_valid", 72'(matrix_valid_o), 72'd0);
      check("reset_pixels", matrix_pixels_o, 72'd0);
      check("reset_frame_done", 72'(frame_done_o), 72'd0);
      check("reset_pixel_ready", 72'(pixel_ready_o), 72'd1);
      nreset_i = 1'b1;
      @(posedge clk);
      #1;

      // Ramp frame against the hand-written window table, 1-cycle latency
      foreach (tbl[i]) exp_q.push_back(tbl[i].win);
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            send_pixel(8'(r * 16 + c), 1'b0);
            hit = -1;
            for (int i = 0; i < 6; i++)
               if (tbl[i].trig == 8'(r * 16 + c)) hit = i;
            check("t1_valid", 72'(matrix_valid_o), 72'(hit >= 0));
            if (hit >= 0) check("t1_window", matrix_pixels_o, tbl[hit].win);
            check("t1_frame_done", 72'(frame_done_o), 72'(r == H - 1 && c == W - 1));
         end
      end
      drain();
      check_counts("ramp", 6, 1);

      // Backpressure while the window for 0x23 is pending
      send_frame(0, 0, 1'b0, 2 * W + 3);
      drain();
      check_counts("backpressure", 6, 1);

      // Random pixels, random gaps, random downstream ready
      rdy_rand = 1'b1;
      for (int k = 0; k < 3; k++) begin
         send_frame(1, 0, 1'b1, -1);
         drain();
         check_counts("random", 6, 1);
      end
      rdy_rand = 1'b0;

      // Two back-to-back frames, second one offset by 0x80
      send_frame(0, 0, 1'b0, -1);
      send_frame(0, 8'h80, 1'b0, -1);
      drain();
      check_counts("b2b", 12, 2);

      // Asynchronous reset in the middle of a frame, after pixel 0x21
      for (int i = 0; i < 2 * W + 2; i++)
         send_pixel(8'((i / W) * 16 + (i % W)), 1'b0);
      pixel_valid_i = 1'b0;
      nreset_i      = 1'b0;
      #1;
      check("midreset_valid", 72'(matrix_valid_o), 72'd0);
      check("midreset_pixels", matrix_pixels_o, 72'd0);
      check("midreset_frame_done", 72'(frame_done_o), 72'd0);
      @(posedge clk);
      #1;
      check("midreset_hold_pixels", matrix_pixels_o, 72'd0);
      nreset_i = 1'b1;
      win_cnt  = 0;
      fd_cnt   = 0;
      @(posedge clk);
      #1;
      send_frame(0, 0, 1'b0, -1);
      drain();
      check_counts("after_reset", 6, 1);

      // Clear while a window is pending
      for (int i = 0; i < 2 * W + 3; i++)
         send_pixel(8'((i / W) * 16 + (i % W)), 1'b0);
      rdy_manual    = 1'b0;
      clear_i       = 1'b1;
      pixel_i       = 8'h55;
      pixel_valid_i = 1'b1;
      @(negedge clk);
      check("clear_pending", 72'(matrix_valid_o), 72'd1);
      check("clear_pixel_ready", 72'(pixel_ready_o), 72'd0);
      @(posedge clk);
      #1;
      clear_i       = 1'b0;
      pixel_valid_i = 1'b0;
      check("clear_drop", 72'(matrix_valid_o), 72'd0);
      rdy_manual = 1'b1;
      send_frame(0, 0, 1'b0, -1);
      drain();
      check_counts("after_clear", 6, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
